// File: rtl/lm96570_spi_ctrl.sv
// lm96570_spi_ctrl
//   SPI-style serial loader for the LM96570 beamformer. A frame of up to
//   MAX_BITS bits is shifted out LSB-first on spi_sdo/spi_sclk, followed by
//   a CLK_DIV-cycle spi_le latch pulse and a one-cycle done pulse.
//
//   Optional feature: define LM96570_SPI_READBACK_EN to capture spi_sdi on
//   every rising spi_sclk edge into a shadow frame that is copied to dout on
//   the done cycle. Without it dout is tied to 0 and spi_sdi is ignored.
//
// Ports
//   clk_clk        single clock, rising edge
//   reset_reset_n  asynchronous active-low reset
//   start          single-cycle transfer request (honoured in IDLE only)
//   din[69:0]      transmit frame, bit 0 first
//   num_of_bits    frame length, clamped to MAX_BITS
//   dout[69:0]     readback frame (bit k = k-th received bit)
//   busy / done    transfer in progress / completion pulse
//   spi_sclk, spi_sdo, spi_le  serial outputs to the device
//   spi_sdi        serial input from the device
module lm96570_spi_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int MAX_BITS = 70
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic [69:0] din,
    input  logic [7:0]  num_of_bits,
    output logic [69:0] dout,
    output logic        busy,
    output logic        done,
    output logic        spi_sclk,
    output logic        spi_sdo,
    input  logic        spi_sdi,
    output logic        spi_le
);

    localparam int              FRAME_W  = 70;
    localparam int              IDX_W    = $clog2(FRAME_W);
    localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]      MAX_N    = 8'(MAX_BITS);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

    state_t               state;
    logic                 armed;    // start captured; shifting begins next edge
    logic [FRAME_W-1:0]   sr;       // transmit shift register, sr[0] is next bit
    logic [7:0]           n_q;
    logic [7:0]           bit_cnt;
    logic [7:0]           div_cnt;
    logic [7:0]           n_clamp;
    logic                 div_tick;
    logic                 accept;
    logic                 done_set;

    assign n_clamp  = (num_of_bits > MAX_N) ? MAX_N : num_of_bits;
    assign div_tick = (div_cnt == DIV_LAST);
    assign accept   = (state == IDLE) && !armed && start;
    // Edge at which done is raised: end of LATCH, or the empty-frame shortcut.
    assign done_set = ((state == LATCH) && div_tick) ||
                      ((state == IDLE) && armed && (n_q == 8'd0));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            sr       <= '0;
            n_q      <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_sclk <= 1'b0;
            spi_sdo  <= 1'b0;
            spi_le   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (armed) begin
                        // One setup cycle after the start edge so the first
                        // low phase is a full CLK_DIV cycles after busy rises.
                        armed   <= 1'b0;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        if (n_q == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= SHIFT_LO;
                            spi_sdo <= sr[0];
                        end
                    end else if (start) begin
                        armed <= 1'b1;
                        sr    <= din;
                        n_q   <= n_clamp;
                    end
                end
                SHIFT_LO: begin
                    if (div_tick) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b1;
                        state    <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (div_tick) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b0;
                        if (bit_cnt == n_q - 8'd1) begin
                            state   <= LATCH;
                            spi_le  <= 1'b1;
                            spi_sdo <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                            sr      <= sr >> 1;
                            spi_sdo <= sr[1];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                LATCH: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        spi_le  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LM96570_SPI_READBACK_EN
    logic [FRAME_W-1:0] shadow;

    // Shadow is cleared on accept so bits beyond N read back as 0; bit k is
    // captured on the edge that raises spi_sclk for bit k.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            shadow <= '0;
            dout   <= '0;
        end else begin
            if (accept)
                shadow <= '0;
            else if ((state == SHIFT_LO) && div_tick)
                shadow[bit_cnt[IDX_W-1:0]] <= spi_sdi;
            if (done_set)
                dout <= shadow;
        end
    end
`else
    logic unused_rb;
    assign unused_rb = spi_sdi ^ accept ^ done_set;
    assign dout      = '0;
`endif

endmodule

// File: tb/tb_lm96570_spi_ctrl.sv
// Directed bench for lm96570_spi_ctrl (CLK_DIV=4, MAX_BITS=70).
// Edge 0 is the clock edge that samples start; outputs are observed 1 ns
// after each rising edge. spi_sdi is looped back from spi_sdo, so the
// readback build returns the transmitted frame masked to N bits.
module tb_lm96570_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [69:0] din = '0;
    logic [7:0]  nb = '0;
    logic [69:0] dout;
    logic        busy, done, spi_sclk, spi_sdo, spi_sdi, spi_le;

    int n_cmp = 0;
    int n_err = 0;

    assign spi_sdi = spi_sdo;

    lm96570_spi_ctrl #(.CLK_DIV(4), .MAX_BITS(70)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .start         (start),
        .din           (din),
        .num_of_bits   (nb),
        .dout          (dout),
        .busy          (busy),
        .done          (done),
        .spi_sclk      (spi_sclk),
        .spi_sdo       (spi_sdo),
        .spi_sdi       (spi_sdi),
        .spi_le        (spi_le)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [69:0] rb(input logic [69:0] v);
`ifdef LM96570_SPI_READBACK_EN
        return v;
`else
        return '0 & v;
`endif
    endfunction

    // One transfer, observed for 580 edges. restart_e >= 0 re-pulses start
    // so that it is sampled at that edge; rel_rst releases reset together
    // with the start request.
    task automatic xfer(input string tag, input logic [69:0] d, input logic [7:0] nbits,
                        input int exp_pulses, input int exp_first, input int exp_le_first,
                        input int exp_done, input logic [69:0] exp_dout,
                        input int restart_e, input bit rel_rst);
        int pulses = 0, first_rise = -1, le_first = -1, le_cnt = 0;
        int done_cnt = 0, done_edge = -1, sdo_err = 0;
        logic busy1 = 1'b0, busy_done = 1'b0, prev = 1'b0;
        logic [69:0] dout_done = '0;
        @(negedge clk);
        if (rel_rst) rst_n = 1'b1;
        din = d; nb = nbits; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din = ~d; nb = 8'd3;            // must not disturb the latched frame
        for (int e = 1; e <= 580; e++) begin
            start = (e == restart_e);
            @(posedge clk); #1;
            if (e == 1) busy1 = busy;
            if (spi_sclk && !prev) begin
                if (pulses == 0) first_rise = e;
                pulses++;
            end
            if (spi_sclk && (pulses > 70 || spi_sdo !== d[pulses-1])) sdo_err++;
            if (spi_le) begin
                if (le_cnt == 0) le_first = e;
                le_cnt++;
                if (spi_sdo !== 1'b0) sdo_err++;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_edge = e; busy_done = busy; dout_done = dout;
                end
            end
            prev = spi_sclk;
        end
        start = 1'b0;
        chk({tag, " busy@1"},    70'(busy1), 70'(1));
        chk({tag, " pulses"},    70'(pulses), 70'(exp_pulses));
        chk({tag, " first_rise"}, 70'(first_rise), 70'(exp_first));
        chk({tag, " sdo_err"},   70'(sdo_err), 70'(0));
        chk({tag, " le_first"},  70'(le_first), 70'(exp_le_first));
        chk({tag, " le_cnt"},    70'(le_cnt), 70'(exp_pulses == 0 ? 0 : 4));
        chk({tag, " done_cnt"},  70'(done_cnt), 70'(1));
        chk({tag, " done_edge"}, 70'(done_edge), 70'(exp_done));
        chk({tag, " busy@done"}, 70'(busy_done), 70'(exp_pulses == 0));
        chk({tag, " dout"},      dout_done, exp_dout);
    endtask

    localparam logic [69:0] PAT  = 70'h2A_5555_5555_AAAA_AAAA;
    localparam logic [69:0] C3F  = 70'h3F_0000_0000_0000_00C3;
    localparam logic [69:0] PAT2 = 70'h01_2345_6789_ABCD_EF01;

    initial begin
        int le_seen;
        // reset state
        #1;
        chk("reset outs", {busy, done, spi_sclk, spi_sdo, spi_le}, 70'(0));
        chk("reset dout", dout, 70'(0));
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // full frame: 70 pulses, LE 561..564, done 565
        xfer("n70", PAT, 8'd70, 70, 5, 561, 565, rb(PAT), -1, 1'b0);
        // clamp 200 -> 70, identical timing
        xfer("n200", PAT2, 8'd200, 70, 5, 561, 565, rb(PAT2), -1, 1'b0);
        // empty frame
        xfer("n0", PAT, 8'd0, 0, -1, -1, 1, 70'(0), -1, 1'b0);
        // 8-bit readback, upper din bits must not appear in dout
        xfer("n8", C3F, 8'd8, 8, 5, 65, 69, rb(70'h0C3), -1, 1'b0);
        // start re-pulsed at edge 10 is ignored
        xfer("restart", C3F, 8'd8, 8, 5, 65, 69, rb(70'h0C3), 10, 1'b0);

        // reset at edge 50 of an N=70 transfer
        le_seen = 0;
        @(negedge clk); din = PAT; nb = 8'd70; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk); #1;
            if (e == 50) chk("mid busy", 70'(busy), 70'(1));
            if (spi_le) le_seen++;
        end
        rst_n = 1'b0; #1;
        chk("abort outs", {busy, done, spi_sclk, spi_sdo, spi_le}, 70'(0));
        chk("abort dout", dout, 70'(0));
        repeat (3) begin
            @(posedge clk); #1;
            if (spi_le || busy || spi_sclk) le_seen++;
        end
        chk("abort no le", 70'(le_seen), 70'(0));
        // start accepted on the first edge after release
        xfer("post_rst", C3F, 8'd8, 8, 5, 65, 69, rb(70'h0C3), -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
